fft32_reorder_pingpong: RTL and testbench

- Output-reorder stage after the last butterfly of the 32-point radix-2 MDC FFT.
- Accepts bins two per beat in bit-reversed order, over 16 accepted beats per frame.
- Buffers each frame in one of two ping-pong banks.
- Streams the frame out in natural order, one bin per cycle, under a valid/ready handshake; upstream is throttled with in_ready when both banks are occupied.

---
 rtl/fft32_reorder_pingpong_pkg.sv | 19 +
 rtl/fft32_reorder_bank.sv | 41 ++++
 rtl/fft32_reorder_pingpong.sv | 121 ++++++++++++
 tb/tb_fft32_reorder_pingpong.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft32_reorder_pingpong_pkg.sv
// Shared constants, sample type and bit-reversal helper for the 32-point FFT
// output-reorder stage.
package fft32_reorder_pingpong_pkg;

    localparam int FFT_N     = 32;
    localparam int FFT_HALF  = 16;
    localparam int LOG2N     = 5;
    localparam int SAMPLE_DW = 16;

    typedef struct packed {
        logic signed [SAMPLE_DW-1:0] re;
        logic signed [SAMPLE_DW-1:0] im;
    } sample_t;

    function automatic logic [LOG2N-2:0] bitrev4(input logic [LOG2N-2:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

endpackage

// File: rtl/fft32_reorder_bank.sv
// One ping-pong bank: even/odd 16-entry complex arrays written as a pair,
// read combinationally by natural bin index.
module fft32_reorder_bank
    import fft32_reorder_pingpong_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [LOG2N-2:0] wr_addr,
    input  logic [DW-1:0]    wr_re0,
    input  logic [DW-1:0]    wr_im0,
    input  logic [DW-1:0]    wr_re1,
    input  logic [DW-1:0]    wr_im1,
    input  logic [LOG2N-1:0] rd_idx,
    output logic [DW-1:0]    rd_re,
    output logic [DW-1:0]    rd_im
);

    logic [2*DW-1:0] even_mem [FFT_HALF];
    logic [2*DW-1:0] odd_mem  [FFT_HALF];
    logic [2*DW-1:0] rd_word;

    // Lane 0 always holds the even bin and lane 1 the odd bin of a beat.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            even_mem[wr_addr] <= {wr_re0, wr_im0};
            odd_mem[wr_addr]  <= {wr_re1, wr_im1};
        end
    end

    always_comb begin
        rd_word = even_mem[rd_idx[LOG2N-1:1]];
        if (rd_idx[0]) begin
            rd_word = odd_mem[rd_idx[LOG2N-1:1]];
        end
        rd_re = rd_word[2*DW-1:DW];
        rd_im = rd_word[DW-1:0];
    end

endmodule

// File: rtl/fft32_reorder_pingpong.sv
// Reorders bit-reversed two-bin beats into a natural-order one-bin stream,
// double-buffered across two banks with valid/ready on both sides.
module fft32_reorder_pingpong
    import fft32_reorder_pingpong_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             soft_clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_re0,
    input  logic [DW-1:0]    in_im0,
    input  logic [DW-1:0]    in_re1,
    input  logic [DW-1:0]    in_im1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_re,
    output logic [DW-1:0]    out_im,
    output logic [LOG2N-1:0] out_idx,
    output logic             out_last,
    output logic             err_drop
);

    localparam logic [LOG2N-2:0] WR_LAST = (LOG2N-1)'(FFT_HALF - 1);
    localparam logic [LOG2N-1:0] RD_LAST = LOG2N'(FFT_N - 1);

    logic             wr_bank;
    logic             rd_bank;
    logic [LOG2N-2:0] wr_cnt;
    logic [LOG2N-1:0] rd_cnt;
    logic [1:0]       full;
    logic [1:0]       full_next;
    logic             accept;
    logic             xfer;
    logic [DW-1:0]    bank_re [2];
    logic [DW-1:0]    bank_im [2];

    assign in_ready  = !full[wr_bank];
    assign accept    = in_valid && in_ready && !soft_clr;
    assign out_valid = full[rd_bank];
    assign xfer      = out_valid && out_ready;
    assign out_idx   = rd_cnt;
    assign out_last  = out_valid && (rd_cnt == RD_LAST);
    assign out_re    = bank_re[rd_bank];
    assign out_im    = bank_im[rd_bank];

    fft32_reorder_bank #(.DW(DW)) u_bank0 (
        .clk     (clk),
        .wr_en   (accept && !wr_bank),
        .wr_addr (bitrev4(wr_cnt)),
        .wr_re0  (in_re0),
        .wr_im0  (in_im0),
        .wr_re1  (in_re1),
        .wr_im1  (in_im1),
        .rd_idx  (rd_cnt),
        .rd_re   (bank_re[0]),
        .rd_im   (bank_im[0])
    );

    fft32_reorder_bank #(.DW(DW)) u_bank1 (
        .clk     (clk),
        .wr_en   (accept && wr_bank),
        .wr_addr (bitrev4(wr_cnt)),
        .wr_re0  (in_re0),
        .wr_im0  (in_im0),
        .wr_re1  (in_re1),
        .wr_im1  (in_im1),
        .rd_idx  (rd_cnt),
        .rd_re   (bank_re[1]),
        .rd_im   (bank_im[1])
    );

    // Fill and drain can complete together; they always touch different banks.
    always_comb begin
        full_next = full;
        if (xfer && rd_cnt == RD_LAST) begin
            full_next[rd_bank] = 1'b0;
        end
        if (accept && wr_cnt == WR_LAST) begin
            full_next[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            full     <= '0;
            err_drop <= 1'b0;
        end else if (soft_clr) begin
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            full     <= '0;
            err_drop <= 1'b0;
        end else begin
            if (in_valid && !in_ready) begin
                err_drop <= 1'b1;
            end
            if (accept) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_cnt == WR_LAST) begin
                    wr_bank <= !wr_bank;
                end
            end
            if (xfer) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_cnt == RD_LAST) begin
                    rd_bank <= !rd_bank;
                end
            end
            full <= full_next;
        end
    end

endmodule

// File: tb/tb_fft32_reorder_pingpong.sv
// Self-checking bench for fft32_reorder_pingpong: frame-level reference model
// plus directed table and corner-case sequences.
module tb_fft32_reorder_pingpong;
    import fft32_reorder_pingpong_pkg::*;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          soft_clr;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_re0, in_im0, in_re1, in_im1;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_re, out_im;
    logic [4:0]    out_idx;
    logic          out_last;
    logic          err_drop;

    int checks = 0;
    int passes = 0;

    // Reference model: whole frames in natural order, counted as complete frames.
    sample_t exp_q[$];
    sample_t part[32];
    int      pend;
    int      rd_pos;
    int      wr_beats;
    int      beat_no;
    logic    m_err;

    typedef struct {
        logic [4:0]    idx;
        logic [DW-1:0] exp_re;
        logic          exp_last;
    } vec_t;
    vec_t tbl[32];

    fft32_reorder_pingpong #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .soft_clr  (soft_clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re0    (in_re0),
        .in_im0    (in_im0),
        .in_re1    (in_re1),
        .in_im1    (in_im1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .err_drop  (err_drop)
    );

    always #5 clk = ~clk;

    function automatic int rev4(input int k);
        int r = 0;
        for (int i = 0; i < 4; i++) begin
            if ((k >> i) & 1) r |= 1 << (3 - i);
        end
        return r;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        pend     = 0;
        rd_pos   = 0;
        wr_beats = 0;
        m_err    = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic checkOutput();
        chk("in_ready", {31'b0, in_ready}, {31'b0, pend < 2});
        chk("out_valid", {31'b0, out_valid}, {31'b0, pend > 0});
        chk("err_drop", {31'b0, err_drop}, {31'b0, m_err});
        chk("out_idx", {27'b0, out_idx}, rd_pos);
        chk("out_last", {31'b0, out_last}, {31'b0, (pend > 0) && (rd_pos == 31)});
        if (pend > 0) begin
            chk("out_re", {16'b0, out_re}, {16'b0, exp_q[0].re});
            chk("out_im", {16'b0, out_im}, {16'b0, exp_q[0].im});
        end
    endtask

    // Drive one cycle's inputs and advance the model over the coming edge.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] r0, input logic [DW-1:0] i0,
                                 input logic [DW-1:0] r1, input logic [DW-1:0] i1,
                                 input logic ordy, input logic clr);
        logic acc, xf;
        int   k;
        in_valid  = v;
        in_re0    = r0;
        in_im0    = i0;
        in_re1    = r1;
        in_im1    = i1;
        out_ready = ordy;
        soft_clr  = clr;
        acc = v && (pend < 2);
        xf  = (pend > 0) && ordy;
        if (clr) begin
            model_clear();
        end else begin
            if (v && !(pend < 2)) m_err = 1'b1;
            if (xf) begin
                void'(exp_q.pop_front());
                if (rd_pos == 31) begin
                    rd_pos = 0;
                    pend--;
                end else begin
                    rd_pos++;
                end
            end
            if (acc) begin
                k = wr_beats;
                part[2*rev4(k)]   = '{re: r0, im: i0};
                part[2*rev4(k)+1] = '{re: r1, im: i1};
                beat_no++;
                wr_beats++;
                if (wr_beats == 16) begin
                    for (int i = 0; i < 32; i++) exp_q.push_back(part[i]);
                    pend++;
                    wr_beats = 0;
                end
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [DW-1:0] r0, input logic [DW-1:0] i0,
                         input logic [DW-1:0] r1, input logic [DW-1:0] i1,
                         input logic ordy, input logic clr);
        applyStimulus(v, r0, i0, r1, i1, ordy, clr);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle(input int n, input logic ordy);
        repeat (n) cycle(1'b0, '0, '0, '0, '0, ordy, 1'b0);
    endtask

    // Next beat of a frame whose bin b carries re=base+b, im=-(base+b).
    task automatic feed_nat(input int base, input logic ordy);
        int b0;
        b0 = base + 2*rev4(wr_beats);
        cycle(1'b1, DW'(b0), DW'(-b0), DW'(b0 + 1), DW'(-(b0 + 1)), ordy, 1'b0);
    endtask

    task automatic async_reset();
        #2;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        soft_clr  = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_err_drop", {31'b0, err_drop}, 32'd0);
        chk("rst_out_last", {31'b0, out_last}, 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput();
    endtask

    int exp_tags[32] = '{100, 101, 116, 117, 108, 109, 124, 125,
                         104, 105, 120, 121, 112, 113, 128, 129,
                         102, 103, 118, 119, 110, 111, 126, 127,
                         106, 107, 122, 123, 114, 115, 130, 131};

    initial begin
        int ocount, start, f, nxt;
        logic v, ordy, clr;

        for (int i = 0; i < 32; i++) begin
            tbl[i] = '{idx: 5'(i), exp_re: DW'(exp_tags[i]), exp_last: (i == 31)};
        end

        rst_n     = 1'b0;
        soft_clr  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_re0 = '0; in_im0 = '0; in_re1 = '0; in_im1 = '0;
        beat_no = 0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkOutput();

        // Single frame through the bit-reversal table.
        for (int k = 0; k < 16; k++) begin
            cycle(1'b1, DW'(100 + 2*k), DW'(-(100 + 2*k)), DW'(101 + 2*k), DW'(-(101 + 2*k)), 1'b1, 1'b0);
        end
        for (int i = 0; i < 32; i++) begin
            chk("tbl_valid", {31'b0, out_valid}, 32'd1);
            chk("tbl_idx", {27'b0, out_idx}, {27'b0, tbl[i].idx});
            chk("tbl_re", {16'b0, out_re}, {16'b0, tbl[i].exp_re});
            chk("tbl_last", {31'b0, out_last}, {31'b0, tbl[i].exp_last});
            idle(1, 1'b1);
        end

        // Back-to-back three frames with upstream honouring in_ready.
        start  = beat_no;
        ocount = 0;
        for (int c = 1; c <= 120; c++) begin
            f = (beat_no - start) / 16;
            if (pend < 2 && beat_no - start < 48) feed_nat(32*f, 1'b1);
            else idle(1, 1'b1);
            if (out_valid) ocount++;
            if (c == 31) chk("b2b_ready_c31", {31'b0, in_ready}, 32'd1);
            if (c == 32) chk("b2b_ready_c32", {31'b0, in_ready}, 32'd0);
            if (c == 47) chk("b2b_ready_c47", {31'b0, in_ready}, 32'd0);
            if (c == 48) chk("b2b_ready_c48", {31'b0, in_ready}, 32'd1);
        end
        chk("b2b_out_count", ocount, 32'd96);
        chk("b2b_err", {31'b0, err_drop}, 32'd0);

        // Output stall at index 7.
        for (int k = 0; k < 16; k++) feed_nat(0, 1'b0);
        idle(7, 1'b1);
        for (int i = 0; i < 10; i++) begin
            idle(1, 1'b0);
            chk("stall_re", {16'b0, out_re}, 32'd7);
            chk("stall_idx", {27'b0, out_idx}, 32'd7);
        end
        nxt = 7;
        for (int i = 0; i < 25; i++) begin
            if (out_valid) begin
                chk("stall_seq", {16'b0, out_re}, nxt);
                nxt++;
            end
            idle(1, 1'b1);
        end
        chk("stall_total", nxt, 32'd32);

        // Drop while both banks are full; data must survive, soft_clr clears the flag.
        for (int i = 0; i < 32; i++) begin
            cycle(1'b1, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom), 1'b0, 1'b0);
        end
        cycle(1'b1, 16'h5555, 16'h5555, 16'h5555, 16'h5555, 1'b0, 1'b0);
        chk("drop_set", {31'b0, err_drop}, 32'd1);
        idle(3, 1'b0);
        chk("drop_sticky", {31'b0, err_drop}, 32'd1);
        idle(64, 1'b1);
        chk("drop_still", {31'b0, err_drop}, 32'd1);
        cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        chk("drop_clr", {31'b0, err_drop}, 32'd0);

        // Asynchronous reset mid-stream with err_drop set and data buffered.
        for (int i = 0; i < 32; i++) feed_nat(200, 1'b0);
        cycle(1'b1, '0, '0, '0, '0, 1'b1, 1'b0);
        idle(3, 1'b1);
        async_reset();
        for (int k = 0; k < 16; k++) feed_nat(300, 1'b0);
        chk("post_rst_valid", {31'b0, out_valid}, 32'd1);
        chk("post_rst_re", {16'b0, out_re}, 32'd300);
        idle(33, 1'b1);

        // Flush with frame 0 half drained and frame 1 at 9 beats.
        for (int k = 0; k < 16; k++) feed_nat(400, 1'b0);
        idle(7, 1'b1);
        for (int k = 0; k < 9; k++) feed_nat(500, 1'b1);
        cycle(1'b1, '0, '0, '0, '0, 1'b1, 1'b1);
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_ready", {31'b0, in_ready}, 32'd1);
        for (int k = 0; k < 16; k++) feed_nat(600, 1'b0);
        chk("flush_new_idx", {27'b0, out_idx}, 32'd0);
        chk("flush_new_re", {16'b0, out_re}, 32'd600);
        idle(33, 1'b1);

        // Randomised traffic with rare violations and flushes.
        for (int i = 0; i < 1500; i++) begin
            v    = ($urandom_range(99) < 60) && ((pend < 2) || ($urandom_range(99) < 3));
            ordy = $urandom_range(99) < 70;
            clr  = $urandom_range(199) == 0;
            cycle(v, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom), ordy, clr);
        end
        idle(70, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
